// File: rtl/exe_pkg.sv
// rtl/exe_pkg.sv - command, forwarding and state encodings for the multi-cycle execute stage
package exe_pkg;

    typedef enum logic [3:0] {
        CMD_NOP  = 4'd0,
        CMD_ADD  = 4'd1,
        CMD_SUB  = 4'd2,
        CMD_AND  = 4'd3,
        CMD_OR   = 4'd4,
        CMD_NOR  = 4'd5,
        CMD_XOR  = 4'd6,
        CMD_SLL  = 4'd7,
        CMD_SRL  = 4'd8,
        CMD_SRA  = 4'd9,
        CMD_MULT = 4'd10,
        CMD_DIV  = 4'd11,
        CMD_MFHI = 4'd12,
        CMD_MFLO = 4'd13
    } exe_cmd_e;

    localparam logic [1:0] FWD_REG = 2'd0;
    localparam logic [1:0] FWD_MEM = 2'd1;
    localparam logic [1:0] FWD_WB  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } md_state_e;

    function automatic logic is_muldiv(input logic [3:0] cmd);
        return (cmd == CMD_MULT) || (cmd == CMD_DIV);
    endfunction

endpackage

// File: rtl/exe_muldiv_unit.sv
// rtl/exe_muldiv_unit.sv - iterative unsigned multiply/divide with architectural HI/LO
module exe_muldiv_unit
    import exe_pkg::*;
#(
    parameter int WORD_LEN = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                is_div,
    input  logic                flush,
    input  logic [WORD_LEN-1:0] op_a,
    input  logic [WORD_LEN-1:0] op_b,
    output logic                busy,
    output logic                idle,
    output logic                finish,
    output logic [WORD_LEN-1:0] res_lo,
    output logic [WORD_LEN-1:0] hi,
    output logic [WORD_LEN-1:0] lo
);

    localparam int CW = $clog2(WORD_LEN);
    localparam logic [CW-1:0] CNT_LAST = CW'(WORD_LEN - 1);

    md_state_e               state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [2*WORD_LEN-1:0]   p_q, p_d, p_step, p_mul, p_div;
    logic [WORD_LEN-1:0]     b_q, b_d, hi_q, hi_d, lo_q, lo_d;
    logic [WORD_LEN:0]       mul_sum, div_shift;
    logic                    div_ge, iterating, last_step;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = is_div ? ST_DIV : ST_MUL;
            ST_MUL, ST_DIV: begin
                if (flush)              state_d = ST_IDLE;
                else if (cnt_q == '0)   state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        iterating = (state_q == ST_MUL) || (state_q == ST_DIV);
        last_step = iterating && !flush && (cnt_q == '0);
        busy      = (state_q != ST_IDLE);
        idle      = (state_q == ST_IDLE);
        finish    = last_step;
    end

    // P holds {upper, lower}: {partial product, multiplier} or {remainder, quotient}
    always_comb begin
        mul_sum   = {1'b0, p_q[2*WORD_LEN-1:WORD_LEN]}
                  + (p_q[0] ? {1'b0, b_q} : {(WORD_LEN+1){1'b0}});
        p_mul     = {mul_sum, p_q[WORD_LEN-1:1]};
        div_shift = p_q[2*WORD_LEN-1:WORD_LEN-1];
        div_ge    = (div_shift >= {1'b0, b_q});
        p_div     = {(div_ge ? (div_shift[WORD_LEN-1:0] - b_q) : div_shift[WORD_LEN-1:0]),
                     p_q[WORD_LEN-2:0], div_ge};
        p_step    = (state_q == ST_DIV) ? p_div : p_mul;
        res_lo    = p_step[WORD_LEN-1:0];
    end

    always_comb begin
        p_d   = p_q;
        b_d   = b_q;
        cnt_d = cnt_q;
        hi_d  = hi_q;
        lo_d  = lo_q;
        if (start && idle) begin
            p_d   = {{WORD_LEN{1'b0}}, op_a};
            b_d   = op_b;
            cnt_d = CNT_LAST;
        end else if (iterating && flush) begin
            cnt_d = '0;
        end else if (iterating) begin
            p_d = p_step;
            if (cnt_q == '0) begin
                hi_d = p_step[2*WORD_LEN-1:WORD_LEN];
                lo_d = p_step[WORD_LEN-1:0];
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q   <= '0;
            b_q   <= '0;
            cnt_q <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
        end else begin
            p_q   <= p_d;
            b_q   <= b_d;
            cnt_q <= cnt_d;
            hi_q  <= hi_d;
            lo_q  <= lo_d;
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule

// File: rtl/exe_stage_mc.sv
// rtl/exe_stage_mc.sv - multi-cycle execute stage: forwarding, ALU, handshake, registered results
module exe_stage_mc
    import exe_pkg::*;
#(
    parameter int WORD_LEN     = 32,
    parameter int FORW_SEL_LEN = 2,
    parameter int EXE_CMD_LEN  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    flush,
    input  logic [EXE_CMD_LEN-1:0]  exe_cmd,
    input  logic [FORW_SEL_LEN-1:0] val1_sel,
    input  logic [FORW_SEL_LEN-1:0] val2_sel,
    input  logic [WORD_LEN-1:0]     val1,
    input  logic [WORD_LEN-1:0]     val2,
    input  logic [WORD_LEN-1:0]     ba_reg,
    input  logic [WORD_LEN-1:0]     alu_res_mem,
    input  logic [WORD_LEN-1:0]     result_wb,
    input  logic                    mem_w_en,
    input  logic                    mem_r_en,
    output logic                    out_valid,
    output logic [WORD_LEN-1:0]     alu_result,
    output logic [WORD_LEN-1:0]     st_value_out,
    output logic [WORD_LEN-1:0]     hi_out,
    output logic [WORD_LEN-1:0]     lo_out,
    output logic                    busy
);

    logic [3:0]          cmd;
    logic                accept, md_cmd, single_acc, md_start;
    logic                md_busy, md_idle, md_finish;
    logic [4:0]          sh;
    logic [WORD_LEN-1:0] op_a_base, op_a, op_b, alu_val;
    logic [WORD_LEN-1:0] md_res_lo, md_hi, md_lo;
    logic                out_valid_d, out_valid_q;
    logic [WORD_LEN-1:0] alu_result_d, alu_result_q, st_value_d, st_value_q;

    function automatic logic [WORD_LEN-1:0] fwd(input logic [FORW_SEL_LEN-1:0] sel,
                                                input logic [WORD_LEN-1:0] base,
                                                input logic [WORD_LEN-1:0] mem,
                                                input logic [WORD_LEN-1:0] wb);
        case (sel)
            FWD_MEM: return mem;
            FWD_WB:  return wb;
            default: return base;
        endcase
    endfunction

    assign cmd = exe_cmd[3:0];

    // Loads and stores address off the base register; forwarding still overrides it
    always_comb begin
        op_a_base = (mem_w_en || mem_r_en) ? ba_reg : val1;
        op_a      = fwd(val1_sel, op_a_base, alu_res_mem, result_wb);
        op_b      = fwd(val2_sel, val2, alu_res_mem, result_wb);
        sh        = op_b[4:0];
    end

    always_comb begin
        alu_val = '0;
        case (cmd)
            CMD_ADD:  alu_val = op_a + op_b;
            CMD_SUB:  alu_val = op_a - op_b;
            CMD_AND:  alu_val = op_a & op_b;
            CMD_OR:   alu_val = op_a | op_b;
            CMD_NOR:  alu_val = ~(op_a | op_b);
            CMD_XOR:  alu_val = op_a ^ op_b;
            CMD_SLL:  alu_val = op_a << sh;
            CMD_SRL:  alu_val = op_a >> sh;
            CMD_SRA:  alu_val = $unsigned($signed(op_a) >>> sh);
            CMD_MFHI: alu_val = md_hi;
            CMD_MFLO: alu_val = md_lo;
            default:  alu_val = '0;
        endcase
    end

    always_comb begin
        accept     = in_valid && md_idle && !flush;
        md_cmd     = is_muldiv(cmd);
        single_acc = accept && !md_cmd;
        md_start   = accept && md_cmd;
    end

    exe_muldiv_unit #(
        .WORD_LEN (WORD_LEN)
    ) u_muldiv (
        .clk    (clk),
        .rst_n  (rst),
        .start  (md_start),
        .is_div (cmd == CMD_DIV),
        .flush  (flush),
        .op_a   (op_a),
        .op_b   (op_b),
        .busy   (md_busy),
        .idle   (md_idle),
        .finish (md_finish),
        .res_lo (md_res_lo),
        .hi     (md_hi),
        .lo     (md_lo)
    );

    // Accept only happens in IDLE and finish only while iterating, so they never collide
    always_comb begin
        out_valid_d  = single_acc || md_finish;
        alu_result_d = alu_result_q;
        if (md_finish)       alu_result_d = md_res_lo;
        else if (single_acc) alu_result_d = alu_val;
        st_value_d   = accept ? val1 : st_value_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q  <= 1'b0;
            alu_result_q <= '0;
            st_value_q   <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            alu_result_q <= alu_result_d;
            st_value_q   <= st_value_d;
        end
    end

    assign in_ready     = md_idle;
    assign busy         = md_busy;
    assign out_valid    = out_valid_q;
    assign alu_result   = alu_result_q;
    assign st_value_out = st_value_q;
    assign hi_out       = md_hi;
    assign lo_out       = md_lo;

endmodule

// File: tb/tb_exe_stage_mc.sv
// tb/tb_exe_stage_mc.sv - self-checking bench for exe_stage_mc against a behavioural model
module tb_exe_stage_mc;

    localparam logic [3:0] NOP = 4'd0, ADD = 4'd1, SUB = 4'd2, AND_ = 4'd3, OR_ = 4'd4,
                           NOR_ = 4'd5, XOR_ = 4'd6, SLL = 4'd7, SRL = 4'd8, SRA = 4'd9,
                           MULT = 4'd10, DIV = 4'd11, MFHI = 4'd12, MFLO = 4'd13;

    logic        clk = 1'b0;
    logic        rst, in_valid, flush, mem_w_en, mem_r_en;
    logic        in_ready, out_valid, busy;
    logic [3:0]  exe_cmd;
    logic [1:0]  val1_sel, val2_sel;
    logic [31:0] val1, val2, ba_reg, alu_res_mem, result_wb;
    logic [31:0] alu_result, st_value_out, hi_out, lo_out;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] hi_m = '0, lo_m = '0, res_m = '0, st_m = '0;

    always #5 clk = ~clk;

    exe_stage_mc #(.WORD_LEN(32), .FORW_SEL_LEN(2), .EXE_CMD_LEN(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
        .exe_cmd(exe_cmd), .val1_sel(val1_sel), .val2_sel(val2_sel),
        .val1(val1), .val2(val2), .ba_reg(ba_reg), .alu_res_mem(alu_res_mem),
        .result_wb(result_wb), .mem_w_en(mem_w_en), .mem_r_en(mem_r_en),
        .out_valid(out_valid), .alu_result(alu_result), .st_value_out(st_value_out),
        .hi_out(hi_out), .lo_out(lo_out), .busy(busy)
    );

    function automatic logic [31:0] fwd_ref(input logic [1:0] sel, input logic [31:0] base,
                                            input logic [31:0] mem, input logic [31:0] wb);
        if (sel == 2'd1) return mem;
        if (sel == 2'd2) return wb;
        return base;
    endfunction

    function automatic logic [31:0] alu_ref(input logic [3:0] c, input logic [31:0] a,
                                            input logic [31:0] b);
        int s;
        s = int'(b % 32);
        case (c)
            ADD:  return a + b;
            SUB:  return a - b;
            AND_: return a & b;
            OR_:  return a | b;
            NOR_: return ~(a | b);
            XOR_: return a ^ b;
            SLL:  return a << s;
            SRL:  return a >> s;
            SRA:  return $unsigned($signed(a) >>> s);
            MFHI: return hi_m;
            MFLO: return lo_m;
            default: return 32'd0;
        endcase
    endfunction

    task automatic idle_inputs();
        in_valid = 0; flush = 0; mem_w_en = 0; mem_r_en = 0; exe_cmd = NOP;
        val1_sel = 0; val2_sel = 0; val1 = 0; val2 = 0; ba_reg = 0;
        alu_res_mem = 0; result_wb = 0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 0; idle_inputs();
        repeat (3) tick();
        checks++; if ({out_valid, busy, alu_result, st_value_out, hi_out, lo_out} !== '0) begin
            errors++; $display("FAIL reset_outputs got ov=%b busy=%b res=%h st=%h hi=%h lo=%h exp all 0",
                               out_valid, busy, alu_result, st_value_out, hi_out, lo_out); end
        @(negedge clk); rst = 1; tick();
        checks++; if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    endtask

    task automatic test_add_fwd();
        exe_cmd = ADD; val1 = 5; val2 = 99; val2_sel = 2; result_wb = 7; in_valid = 1;
        tick(); idle_inputs();
        res_m = 12; st_m = 5;
        checks++; if (out_valid !== 1'b1 || alu_result !== res_m) begin
            errors++; $display("FAIL add_fwd got ov=%b res=%h exp ov=1 res=%h", out_valid, alu_result, res_m); end
        tick();
        checks++; if (out_valid !== 1'b0) begin
            errors++; $display("FAIL add_strobe_width got ov=%b exp 0", out_valid); end
    endtask

    task automatic test_store_base();
        exe_cmd = ADD; mem_w_en = 1; ba_reg = 32'h100; val2 = 8; val1 = 32'hAB; in_valid = 1;
        tick(); idle_inputs();
        res_m = 32'h108; st_m = 32'hAB;
        checks++; if (alu_result !== res_m || st_value_out !== st_m) begin
            errors++; $display("FAIL store_base got res=%h st=%h exp res=%h st=%h",
                               alu_result, st_value_out, res_m, st_m); end
    endtask

    task automatic test_back_to_back(input int n);
        logic [31:0] a, b;
        int c;
        for (int i = 0; i < n; i++) begin
            c = $urandom_range(0, 11);
            if (c >= 10) c += 2;
            exe_cmd = 4'(c); in_valid = 1;
            val1 = $urandom; val2 = $urandom; ba_reg = $urandom;
            alu_res_mem = $urandom; result_wb = $urandom;
            if (i % 3 == 0) val2 = $urandom_range(0, 40);
            val1_sel = 2'($urandom_range(0, 3)); val2_sel = 2'($urandom_range(0, 3));
            mem_w_en = ($urandom_range(0, 3) == 0); mem_r_en = ($urandom_range(0, 3) == 0);
            a = fwd_ref(val1_sel, (mem_w_en | mem_r_en) ? ba_reg : val1, alu_res_mem, result_wb);
            b = fwd_ref(val2_sel, val2, alu_res_mem, result_wb);
            res_m = alu_ref(exe_cmd, a, b); st_m = val1;
            tick();
            checks++; if (out_valid !== 1'b1 || alu_result !== res_m || st_value_out !== st_m) begin
                errors++; $display("FAIL b2b[%0d] cmd=%0d got ov=%b res=%h st=%h exp res=%h st=%h",
                                   i, c, out_valid, alu_result, st_value_out, res_m, st_m); end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_md(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                           input string name);
        logic [63:0] prod;
        logic [31:0] hi_e, lo_e;
        int cyc;
        for (int i = 0; i < 40 && !in_ready; i++) tick();
        checks++; if (in_ready !== 1'b1) begin
            errors++; $display("FAIL %s_ready_wait got %b exp 1", name, in_ready); end
        if (c == MULT) begin
            prod = {32'd0, a} * {32'd0, b}; hi_e = prod[63:32]; lo_e = prod[31:0];
        end else if (b == 0) begin
            hi_e = a; lo_e = 32'hFFFF_FFFF;
        end else begin
            hi_e = a % b; lo_e = a / b;
        end
        exe_cmd = c; val1 = a; val2 = b; in_valid = 1;
        tick(); idle_inputs();
        cyc = 1;
        while (!out_valid && cyc < 60) begin tick(); cyc++; end
        checks++; if (out_valid !== 1'b1 || cyc != 33) begin
            errors++; $display("FAIL %s_latency got %0d ov=%b exp 33", name, cyc, out_valid); end
        hi_m = hi_e; lo_m = lo_e; res_m = lo_e; st_m = a;
        checks++; if (alu_result !== lo_e || hi_out !== hi_e || lo_out !== lo_e || st_value_out !== st_m) begin
            errors++; $display("FAIL %s_result got res=%h hi=%h lo=%h st=%h exp res=%h hi=%h lo=%h st=%h",
                               name, alu_result, hi_out, lo_out, st_value_out, lo_e, hi_e, lo_e, st_m); end
        checks++; if (in_ready !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL %s_done_busy got rdy=%b busy=%b exp 0 1", name, in_ready, busy); end
        tick();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL %s_return_idle got ov=%b rdy=%b busy=%b exp 0 1 0",
                               name, out_valid, in_ready, busy); end
    endtask

    task automatic test_mult_mfhi();
        int nr, saw, bad_busy;
        exe_cmd = MULT; val1 = 32'hFFFF_FFFF; val2 = 2; in_valid = 1;
        tick();
        exe_cmd = MFHI; val1 = 32'h55; val2 = 0;
        hi_m = 1; lo_m = 32'hFFFF_FFFE;
        nr = 0; saw = 0; bad_busy = 0;
        for (int i = 0; i < 50 && !in_ready; i++) begin
            nr++;
            if (busy !== 1'b1) bad_busy++;
            if (out_valid) begin
                saw++;
                checks++; if (hi_out !== hi_m || lo_out !== lo_m || alu_result !== lo_m) begin
                    errors++; $display("FAIL mult_result got hi=%h lo=%h res=%h exp hi=%h lo=%h",
                                       hi_out, lo_out, alu_result, hi_m, lo_m); end
            end
            tick();
        end
        checks++; if (nr != 33 || saw != 1 || bad_busy != 0) begin
            errors++; $display("FAIL mult_stall got stall=%0d strobes=%0d busy_err=%0d exp 33 1 0",
                               nr, saw, bad_busy); end
        tick(); idle_inputs();
        res_m = 1; st_m = 32'h55;
        checks++; if (out_valid !== 1'b1 || alu_result !== 32'd1 || st_value_out !== st_m) begin
            errors++; $display("FAIL mfhi_queued got ov=%b res=%h st=%h exp 1 00000001 %h",
                               out_valid, alu_result, st_value_out, st_m); end
        tick();
    endtask

    task automatic test_flush();
        int ov_seen;
        exe_cmd = MULT; val1 = 3; val2 = 4; in_valid = 1;
        tick(); idle_inputs();
        st_m = 3;
        repeat (9) tick();
        flush = 1;
        tick();
        flush = 0;
        checks++; if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL flush_abort got rdy=%b busy=%b ov=%b exp 1 0 0", in_ready, busy, out_valid); end
        ov_seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) ov_seen++;
            tick();
        end
        checks++; if (ov_seen != 0 || hi_out !== hi_m || lo_out !== lo_m || alu_result !== res_m) begin
            errors++; $display("FAIL flush_no_result got strobes=%0d hi=%h lo=%h res=%h exp 0 %h %h %h",
                               ov_seen, hi_out, lo_out, alu_result, hi_m, lo_m, res_m); end
        exe_cmd = ADD; val1 = 1; val2 = 1; in_valid = 1; flush = 1;
        tick(); idle_inputs();
        checks++; if (out_valid !== 1'b0 || alu_result !== res_m || st_value_out !== st_m) begin
            errors++; $display("FAIL flush_idle_drop got ov=%b res=%h st=%h exp 0 %h %h",
                               out_valid, alu_result, st_value_out, res_m, st_m); end
    endtask

    task automatic test_reset_mid_div();
        exe_cmd = DIV; val1 = 1000; val2 = 3; in_valid = 1;
        tick(); idle_inputs();
        repeat (5) tick();
        #2 rst = 0;
        #1;
        checks++; if ({out_valid, busy, alu_result, st_value_out, hi_out, lo_out} !== '0) begin
            errors++; $display("FAIL reset_mid_div got ov=%b busy=%b res=%h st=%h hi=%h lo=%h exp all 0",
                               out_valid, busy, alu_result, st_value_out, hi_out, lo_out); end
        hi_m = 0; lo_m = 0; res_m = 0; st_m = 0;
        @(negedge clk); rst = 1;
        repeat (3) tick();
        checks++; if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_release got rdy=%b busy=%b ov=%b exp 1 0 0", in_ready, busy, out_valid); end
    endtask

    initial begin
        test_reset();
        test_add_fwd();
        test_store_base();
        test_back_to_back(40);
        test_mult_mfhi();
        test_md(DIV, 100, 7, "div_100_7");
        test_md(DIV, 9, 0, "div_by_zero");
        for (int i = 0; i < 4; i++) begin
            test_md(MULT, $urandom, $urandom, "mult_rand");
            test_md(DIV, $urandom, $urandom_range(1, 70000), "div_rand");
        end
        test_back_to_back(20);
        test_flush();
        test_reset_mid_div();
        test_md(MULT, 32'h1234_5678, 32'h9ABC_DEF0, "mult_after_reset");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/exe_stage_mc.md
# exe_stage_mc

Parametrised multi-cycle execute stage for the customised MIPS pipeline. It keeps the forwarding-mux and load/store base-address selection of the single-cycle execute path. It adds registered outputs, a valid/ready handshake toward decode, iterative unsigned multiply/divide with architectural HI/LO registers, and a flush input. It sits between the ID/EXE pipeline register and the EXE/MEM register; `busy`/`in_ready` drive the hazard unit's stall.

## Interface
- `WORD_LEN`, 32, datapath width; also the multiply/divide iteration count.
- `FORW_SEL_LEN`, 2, forwarding select width.
- `EXE_CMD_LEN`, 4, command width.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  command presented.
- `in_ready`  out  1  stage can accept a command.
- `flush`  in  1  synchronous abort of the accepted or in-flight op.
- `exe_cmd`  in  `EXE_CMD_LEN`  operation code.
- `val1_sel`, `val2_sel`  in  `FORW_SEL_LEN`  forwarding selects.
- `val1`, `val2`, `ba_reg`, `alu_res_mem`, `result_wb`  in  `WORD_LEN`  operands, base register, forwarded values.
- `mem_w_en`, `mem_r_en`  in  1  load/store qualifiers.
- `out_valid`  out  1  one-cycle result strobe.
- `alu_result`, `st_value_out`  out  `WORD_LEN`  registered result and store data.
- `hi_out`, `lo_out`  out  `WORD_LEN`  HI/LO registers.
- `busy`  out  1  multiply/divide in progress.

## Operation
- **Operand capture:** operands are sampled only on an accepted edge (`in_valid & in_ready & ~flush`).
- **Operand A source:** `mem_w_en | mem_r_en` replaces `val1` by `ba_reg`, before forwarding.
- **Forwarding select codes:** 0 = register/base, 1 = `alu_res_mem`, 2 = `result_wb`, 3 = treated as 0.
- **Store data:** `st_value_out` is registered raw `val1`, with no forwarding.
- **Single-cycle commands:** ADD, SUB, AND, OR, NOR, XOR, SLL, SRL, SRA, NOP.
  - Shift amount is `B[4:0]`.
  - Arithmetic wraps modulo 2^`WORD_LEN`.
- **MFHI/MFLO:** return HI/LO as they stand at acceptance.
- **MULT:** unsigned shift-add, one bit per cycle, 2·`WORD_LEN`-bit product.
  - On completion, HI = upper half and LO = lower half; `alu_result` = LO.
- **DIV:** unsigned restoring division, one bit per cycle.
  - On completion, LO = quotient and HI = remainder; `alu_result` = LO.
  - Divide by zero: LO = all ones, HI = dividend. No exception.
- **State machine:** IDLE → MUL or DIV on an accepted MULT/DIV.
  - The iteration counter runs `WORD_LEN`-1 down to 0.
  - After the last step, go to DONE (one cycle; HI/LO written, `out_valid`=1), then IDLE.
- **Busy and ready:** `busy` = state ∈ {MUL, DIV, DONE}. `in_ready` = state == IDLE.
- **Flush:**
  - In IDLE, it drops a simultaneously presented command.
  - In MUL/DIV, it returns to IDLE next edge with HI/LO unchanged and no `out_valid`.
  - It clears `out_valid` for the next cycle.
  - It has priority over every other event.
- **Reset (any state, including mid-iteration):**
  - State = IDLE, counter = 0.
  - `alu_result`, `st_value_out`, `hi_out`, `lo_out` = 0.
  - `out_valid` = 0, `busy` = 0.
  - `in_ready` = 1 after release.

## Timing
- **Single-cycle ops:** accepted on edge E; `out_valid`, `alu_result` and `st_value_out` are valid in the cycle after E. Back-to-back acceptance every cycle.
- **MULT/DIV:** accepted on edge E; iterations on edges E+1 … E+`WORD_LEN`; DONE cycle follows edge E+`WORD_LEN`.
  - `out_valid` is high in that DONE cycle.
  - `in_ready` returns high in the next cycle.
  - Total latency is `WORD_LEN`+1 cycles to the strobe.
- **Ordering:** an MFHI/MFLO presented while busy stalls until IDLE, so it always observes the completed product or quotient.
- **Stability:** `hi_out`/`lo_out` change only in DONE; `out_valid` never lasts more than one cycle per op.

## Structure
- Package `exe_pkg`:
  - command codes: NOP=0, ADD, SUB, AND, OR, NOR, XOR, SLL, SRL, SRA, MULT, DIV, MFHI, MFLO;
  - forwarding select codes;
  - state enum IDLE/MUL/DIV/DONE.
- Sub-module `exe_muldiv_unit`: iteration registers, counter, HI/LO result. Start/kind/flush in; done/hi/lo out.
- The top level keeps the muxes, single-cycle ALU, handshake and output registers.

## Test plan
- **ADD with WB forwarding:** ADD `val1`=5, `val2_sel`=2, `result_wb`=7 → one cycle later `out_valid`=1, `alu_result`=12.
- **Store base selection:** store with `mem_w_en`=1, `ba_reg`=0x100, `val2`=8, `val1`=0xAB → `alu_result`=0x108, `st_value_out`=0xAB.
- **MULT then MFHI:** MULT 0xFFFFFFFF × 2 → `in_ready`=0 for 33 cycles, then HI=1, LO=0xFFFFFFFE. MFHI queued meanwhile returns 1.
- **DIV:** DIV 100 / 7 → LO=14, HI=2.
- **DIV by zero:** DIV 9 / 0 → LO=0xFFFFFFFF, HI=9.
- **Flush and reset mid-iteration:**
  - Flush on the 10th iteration of MULT 3 × 4 → no `out_valid`, HI/LO unchanged, `in_ready`=1 next cycle.
  - Assert `rst` mid-DIV → all outputs 0 immediately.
